// File: rtl/byte_load_sequencer_if.sv
// Bus bundle for byte_load_sequencer: memory read port, byte-extractor operands
// and the valid/ready byte output stream.
interface byte_load_sequencer_if #(
    parameter int N  = 32,
    parameter int AW = 16
);
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_rdata;
    logic [N-1:0]  ext_word;
    logic [N-1:0]  ext_sel;
    logic [N-1:0]  ext_result;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_byte;

    modport master (
        output mem_rd_en, mem_addr, ext_word, ext_sel, out_valid, out_byte,
        input  mem_rdata, ext_result, out_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, ext_word, ext_sel, out_valid, out_byte,
        output mem_rdata, ext_result, out_ready
    );
endinterface

// File: rtl/byte_load_sequencer.sv
// Streams packed bytes out of word-wide memory: one read per word, then steps the
// external extractor through lanes 1..4, presenting each byte on valid/ready.
module byte_load_sequencer #(
    parameter int N  = 32,
    parameter int AW = 16,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [LW-1:0] word_count,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    byte_load_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } state_t;

    state_t        state;
    logic [AW-1:0] addr;
    logic [LW-1:0] words_left;
    logic [2:0]    lane;
    logic          handshake;
    logic          ext_unused;

    assign handshake    = bus.out_valid && bus.out_ready;
    assign bus.mem_addr = addr;
    assign bus.out_byte = bus.ext_result[7:0];
    assign ext_unused   = ^bus.ext_result[N-1:8];

    // Outputs are registered alongside the state, so each transition also sets
    // the output values that belong to the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            addr          <= '0;
            words_left    <= '0;
            lane          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bus.mem_rd_en <= 1'b0;
            bus.ext_word  <= '0;
            bus.ext_sel   <= '0;
            bus.out_valid <= 1'b0;
        end else if (abort && state != ST_IDLE) begin
            // Abort wins over everything, including a handshake and a word in flight.
            state         <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            bus.mem_rd_en <= 1'b0;
            bus.ext_sel   <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            done          <= 1'b0;
            bus.mem_rd_en <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr       <= base_addr & ~AW'(3);
                        words_left <= word_count;
                        if (word_count == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state         <= ST_FETCH;
                            busy          <= 1'b1;
                            bus.mem_rd_en <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    bus.ext_word  <= bus.mem_rdata;
                    lane          <= 3'd1;
                    addr          <= addr + AW'(4);
                    words_left    <= words_left - LW'(1);
                    state         <= ST_EMIT;
                    bus.ext_sel   <= N'(3'd1);
                    bus.out_valid <= 1'b1;
                end
                ST_EMIT: begin
                    if (handshake) begin
                        if (lane < 3'd4) begin
                            lane        <= lane + 3'd1;
                            bus.ext_sel <= N'(lane + 3'd1);
                        end else begin
                            bus.ext_sel   <= '0;
                            bus.out_valid <= 1'b0;
                            if (words_left != '0) begin
                                state         <= ST_FETCH;
                                bus.mem_rd_en <= 1'b1;
                            end else begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
